// File: rtl/penta_pkg.sv
// penta_pkg: shared event codes and helpers for the five-key event sequencer
package penta_pkg;
    localparam int CODE_W = 3;
    localparam int NKEYS = 5;
    localparam logic [CODE_W-1:0] KEY0 = 3'd0;
    localparam logic [CODE_W-1:0] KEY1 = 3'd1;
    localparam logic [CODE_W-1:0] KEY2 = 3'd2;
    localparam logic [CODE_W-1:0] KEY3 = 3'd3;
    localparam logic [CODE_W-1:0] KEY4 = 3'd4;
    localparam logic [CODE_W-1:0] EV_IDLE = 3'd5;

    function automatic logic [CODE_W-1:0] lowest_index(input logic [NKEYS-1:0] v);
        lowest_index = KEY0;
        for (int i = NKEYS - 1; i >= 0; i--)
            if (v[i]) lowest_index = CODE_W'(i);
    endfunction
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: synchronous show-ahead FIFO holding key event codes
module key_event_fifo
    import penta_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = 3
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              push,
    input  logic [CODE_W-1:0] wdata,
    input  logic              pop,
    output logic [CODE_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);
    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    // a push into a full FIFO is accepted only when the head leaves the same cycle
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge sysclk)
        if (do_push) mem[wr_ptr] <= wdata;

    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/penta_key_sequencer.sv
// penta_key_sequencer: turns debounced key pulses and an idle timeout into an ordered
// stream of event codes delivered over valid/ready
module penta_key_sequencer
    import penta_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = 3,
    parameter int TIMEOUT = 50_000_000,
    parameter int TW = 26
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [NKEYS-1:0]  key_pulse,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [CODE_W-1:0] ev_code,
    output logic [AW:0]       ev_count,
    output logic              overflow,
    input  logic              clr_overflow
);
    logic [NKEYS-1:0] pending, grant_key;
    logic idle_pend, fired, full, empty, pop, can_push, grant_idle, push, merge, timeout_hit;
    logic [TW-1:0] tmo_cnt;
    logic [CODE_W-1:0] push_code;

    assign ev_valid = ~empty;

    always_comb begin
        pop = ev_valid & ev_ready;
        can_push = ~full | pop;
        grant_key = can_push ? (pending & (~pending + 1'b1)) : '0;
        grant_idle = can_push & ~|pending & idle_pend;
        push = |grant_key | grant_idle;
        push_code = |pending ? lowest_index(pending) : EV_IDLE;
        merge = |(key_pulse & pending & ~grant_key);
        timeout_hit = (TIMEOUT != 0) && ~|key_pulse && !fired && tmo_cnt == TW'(TIMEOUT - 1);
    end

    // the counter parks at TIMEOUT-1 once fired, so each quiet period yields one IDLE event
    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            pending <= '0;
            idle_pend <= 1'b0;
            fired <= 1'b0;
            tmo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= (pending & ~grant_key) | key_pulse;
            idle_pend <= (idle_pend & ~grant_idle) | timeout_hit;
            overflow <= merge | (overflow & ~clr_overflow);
            if (|key_pulse) begin
                tmo_cnt <= '0;
                fired <= 1'b0;
            end else if (timeout_hit) begin
                fired <= 1'b1;
            end else if (!fired && TIMEOUT != 0) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end

    key_event_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .sysclk(sysclk),
        .reset(reset),
        .push(push),
        .wdata(push_code),
        .pop(pop),
        .rdata(ev_code),
        .full(full),
        .empty(empty),
        .count(ev_count)
    );
endmodule

// File: tb/tb_penta_key_sequencer.sv
// tb_penta_key_sequencer: directed vector table plus hand-written multi-cycle sequences
`timescale 1ns/1ps
module tb_penta_key_sequencer;
    import penta_pkg::*;

    typedef struct {
        logic [4:0] kp;
        logic rdy;
        logic clr;
        logic v;
        logic [2:0] c;
        logic [3:0] n;
        logic o;
    } vec_t;

    logic sysclk = 1'b0, reset = 1'b0, ev_ready = 1'b0, clr_overflow = 1'b0;
    logic [4:0] key_pulse = '0;
    logic ev_valid, overflow, t_valid, t_overflow;
    logic [2:0] ev_code, t_code;
    logic [3:0] ev_count, t_count;
    int tests = 0, fails = 0;
    vec_t vecs[17];
    logic [2:0] drain[8];

    always #5 sysclk = ~sysclk;

    penta_key_sequencer #(.DEPTH(8), .AW(3), .TIMEOUT(0), .TW(26)) dut (
        .sysclk(sysclk), .reset(reset), .key_pulse(key_pulse), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_count(ev_count),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    penta_key_sequencer #(.DEPTH(8), .AW(3), .TIMEOUT(20), .TW(26)) dut_t (
        .sysclk(sysclk), .reset(reset), .key_pulse(key_pulse), .ev_ready(ev_ready),
        .ev_valid(t_valid), .ev_code(t_code), .ev_count(t_count),
        .overflow(t_overflow), .clr_overflow(clr_overflow)
    );

    task automatic step(input logic [4:0] kp, input logic rdy, input logic clr);
        key_pulse = kp;
        ev_ready = rdy;
        clr_overflow = clr;
        @(posedge sysclk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [2:0] c,
                              input logic [3:0] n, input logic o);
        tests++;
        if ({ev_valid, ev_code, ev_count, overflow} !== {v, c, n, o}) begin
            fails++;
            $display("FAIL %s: got v=%b code=%0d count=%0d ovf=%b, expected v=%b code=%0d count=%0d ovf=%b",
                     name, ev_valid, ev_code, ev_count, overflow, v, c, n, o);
        end
    endtask

    task automatic expect_t(input string name, input logic v, input logic [2:0] c, input logic [3:0] n);
        tests++;
        if ({t_valid, t_code, t_count} !== {v, c, n}) begin
            fails++;
            $display("FAIL %s: got v=%b code=%0d count=%0d, expected v=%b code=%0d count=%0d",
                     name, t_valid, t_code, t_count, v, c, n);
        end
    endtask

    initial begin
        vecs = '{
            '{5'b00100, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 1'b1, 3'd2, 4'd1, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 1'b1, 3'd2, 4'd1, 1'b0},
            '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0},
            '{5'b10011, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 1'b1, 3'd0, 4'd1, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 1'b1, 3'd0, 4'd2, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 1'b1, 3'd0, 4'd3, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 1'b1, 3'd0, 4'd3, 1'b0},
            '{5'b00000, 1'b1, 1'b0, 1'b1, 3'd1, 4'd2, 1'b0},
            '{5'b00000, 1'b1, 1'b0, 1'b1, 3'd4, 4'd1, 1'b0},
            '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0},
            '{5'b00001, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0},
            '{5'b00001, 1'b0, 1'b0, 1'b1, 3'd0, 4'd1, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 1'b1, 3'd0, 4'd2, 1'b0},
            '{5'b00000, 1'b1, 1'b0, 1'b1, 3'd0, 4'd1, 1'b0},
            '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0}
        };
        drain = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd3, 3'd2};

        #1;
        expect_out("reset state", 1'b0, 3'd0, 4'd0, 1'b0);
        expect_t("reset state t", 1'b0, 3'd0, 4'd0);
        #21 reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].kp, vecs[i].rdy, vecs[i].clr);
            expect_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].c, vecs[i].n, vecs[i].o);
        end

        for (int k = 0; k < 8; k++) step((k % 2) ? 5'b00010 : 5'b00001, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        expect_out("full fill", 1'b1, 3'd0, 4'd8, 1'b0);
        step(5'b01000, 1'b0, 1'b0);
        expect_out("full key3 held", 1'b1, 3'd0, 4'd8, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        expect_out("full hold", 1'b1, 3'd0, 4'd8, 1'b0);
        step(5'b01000, 1'b0, 1'b0);
        expect_out("full merge ovf", 1'b1, 3'd0, 4'd8, 1'b1);
        step(5'b00000, 1'b1, 1'b0);
        expect_out("pop admits key3", 1'b1, 3'd1, 4'd8, 1'b1);
        step(5'b00000, 1'b0, 1'b1);
        expect_out("clr ovf", 1'b1, 3'd1, 4'd8, 1'b0);
        step(5'b00100, 1'b0, 1'b0);
        expect_out("key2 held", 1'b1, 3'd1, 4'd8, 1'b0);
        step(5'b00100, 1'b0, 1'b1);
        expect_out("set beats clr", 1'b1, 3'd1, 4'd8, 1'b1);
        step(5'b00000, 1'b0, 1'b1);
        expect_out("clr again", 1'b1, 3'd1, 4'd8, 1'b0);
        step(5'b00000, 1'b1, 1'b0);
        expect_out("push+pop full", 1'b1, 3'd0, 4'd8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            expect_out($sformatf("drain%0d", i), 1'b1, drain[i], 4'(8 - i), 1'b0);
            step(5'b00000, 1'b1, 1'b0);
        end
        expect_out("drained", 1'b0, 3'd0, 4'd0, 1'b0);
        step(5'b00000, 1'b1, 1'b0);
        expect_out("ready on empty", 1'b0, 3'd0, 4'd0, 1'b0);

        step(5'b10011, 1'b0, 1'b0);
        step(5'b00010, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        expect_out("pre-reset", 1'b1, 3'd0, 4'd3, 1'b1);
        #1 reset = 1'b0;
        #1 expect_out("async reset", 1'b0, 3'd0, 4'd0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(5'b00000, 1'b1, 1'b0);
            expect_out($sformatf("no stale %0d", i), 1'b0, 3'd0, 4'd0, 1'b0);
        end

        #1 reset = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < 20; i++) step(5'b00000, 1'b0, 1'b0);
        expect_t("no idle before 21", 1'b0, 3'd0, 4'd0);
        step(5'b00000, 1'b0, 1'b0);
        expect_t("idle at 21", 1'b1, EV_IDLE, 4'd1);
        for (int i = 0; i < 40; i++) step(5'b00000, 1'b0, 1'b0);
        expect_t("single idle", 1'b1, EV_IDLE, 4'd1);
        step(5'b00000, 1'b1, 1'b0);
        expect_t("idle popped", 1'b0, 3'd0, 4'd0);
        step(5'b00010, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        expect_t("key before idle", 1'b1, 3'd1, 4'd1);
        step(5'b00000, 1'b1, 1'b0);
        expect_t("key popped", 1'b0, 3'd0, 4'd0);
        for (int i = 0; i < 18; i++) step(5'b00000, 1'b0, 1'b0);
        expect_t("quiet 20", 1'b0, 3'd0, 4'd0);
        step(5'b00000, 1'b0, 1'b0);
        expect_t("second idle", 1'b1, EV_IDLE, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/penta_key_sequencer.md
Name: penta_key_sequencer

Overview:
- Controller behind the five-button debouncer. It converts the five single-cycle debounced key pulses into an ordered stream of 3-bit key codes.
- Events are buffered in a small FIFO and handed to the consumer (menu/mode FSM) over a valid/ready handshake.
- Adds an inactivity-timeout event and a sticky overflow flag, so no key press is silently lost.

Parameters:
- DEPTH, 8, FIFO depth in entries; power of two, min 2.
- AW, 3, log2(DEPTH).
- TIMEOUT, 50_000_000, sysclk cycles of key silence before an IDLE event is emitted; 0 disables.
- TW, 26, timeout counter width; 2^TW > TIMEOUT.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_pulse  in  5  one-cycle debounced pulses; bit i = key i.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ev_valid  out  1  FIFO non-empty; ev_code is valid.
- ev_code  out  3  head event: 0..4 = key index, 5 = IDLE.
- ev_count  out  AW+1  number of entries currently in the FIFO.
- overflow  out  1  sticky: an event was merged or dropped.
- clr_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, async): pending[4:0]=0, idle_pend=0, timeout counter=0, fired=0, FIFO empty, ev_valid=0, ev_code=0, ev_count=0, overflow=0.
- Pending latch:
  - pending_next = (pending & ~grant) | key_pulse.
  - A pulse on a bit already pending and not granted this cycle is merged and sets overflow.
  - A pulse on the bit being granted this cycle re-arms that bit; overflow is not set.
- Grant:
  - Each cycle, if can_push = (ev_count<DEPTH) | (ev_valid & ev_ready), grant the lowest set pending bit; push its index.
  - If no key is pending, grant idle_pend instead (push code 5).
  - At most one push per cycle.
- FIFO full and no pop: nothing is granted; pending bits hold with no loss.
- Latency: pulse sampled at edge E0 -> pending; pushed at E1; ev_valid=1 after E1, i.e. 2 cycles pulse-to-valid.
- Output is show-ahead: ev_code = head entry combinationally from the FIFO registers.
  - Pop on ev_valid & ev_ready.
  - ev_ready while empty is ignored.
- Simultaneous push and pop: allowed even when full; ev_count unchanged; order preserved.
- Pointers: AW-bit read/write pointers wrap modulo DEPTH; ev_count is a separate AW+1-bit counter.
- Timeout:
  - Counter increments each cycle with key_pulse==0 and fired==0.
  - Any key_pulse bit clears the counter and fired.
  - When the counter reaches TIMEOUT-1: set idle_pend and fired; the counter holds.
  - Result: exactly one IDLE event per quiet period.
  - If a key pulse arrives while idle_pend is still set, the IDLE event is still delivered (after the key).
- overflow: set by a merge (above). A set and clr_overflow in the same cycle leaves overflow set (set wins).
- Multiple simultaneous key_pulse bits (illegal from the debouncer but tolerated): all are latched and drained lowest index first, one per cycle.

Decomposition:
- Shared package penta_pkg: code constants KEY0..KEY4 = 3'd0..3'd4, EV_IDLE = 3'd5, code width 3.
- One sub-module: key_event_fifo. It is a synchronous show-ahead FIFO (DEPTH, width 3) with push, pop, full, empty and count ports.
- Pending/grant/timeout logic stays in the top module.

Test Plan:
- Reset mid-operation: 3 entries queued, then reset low for 1 ns asynchronously -> ev_valid=0, ev_count=0, overflow=0 immediately. After release, no stale codes are emitted.
- Single key: key_pulse=5'b00100 for 1 cycle, ev_ready=0 -> ev_valid rises 2 cycles later with ev_code=2 and ev_count=1. Then ev_ready=1 for 1 cycle -> ev_valid=0, ev_count=0.
- Simultaneous pulses: key_pulse=5'b10011 -> codes 0, 1, 4 pushed on 3 consecutive cycles, ev_count=3, overflow=0.
- Full FIFO, DEPTH=8, ev_ready=0:
  - Pulse keys 0,1,0,1,... for 8 events -> ev_count=8.
  - A further pulse on key 3 holds in pending. A second key 3 pulse -> overflow=1.
  - Popping one entry -> code 3 enters the same cycle, count stays 8.
  - clr_overflow -> overflow=0.
- Full with simultaneous push/pop: FIFO full, ev_ready=1 held, one key pending -> ev_count remains 8 for one cycle. The popped and pushed codes appear in FIFO order.
- Timeout, TIMEOUT=20: no keys -> one code-5 event pushed 21 cycles after reset release, and no second IDLE event. A key pulse followed by 20 quiet cycles -> the key code, then another code 5.
